// File: rtl/updown_counter_param_if.sv
// -----------------------------------------------------------------------------
// updown_counter_param_if
// Groups the control inputs and status outputs of updown_counter_param.
//   master : drives en, updown, wrap_mode, load, load_val; observes count,
//            led, wrap_pulse, tick
//   slave  : the counter itself (mirror of master)
// clk and reset are deliberately kept outside as plain module ports.
// -----------------------------------------------------------------------------
interface updown_counter_param_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             updown;
   logic             wrap_mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             led;
   logic             wrap_pulse;
   logic             tick;

   modport master (
      output en, updown, wrap_mode, load, load_val,
      input  count, led, wrap_pulse, tick
   );

   modport slave (
      input  en, updown, wrap_mode, load, load_val,
      output count, led, wrap_pulse, tick
   );
endinterface

// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
// Up/down counter over [MIN_VAL..MAX_VAL] with an internal clock-enable
// prescaler (one step every DIV clk cycles while en=1), saturate or wrap
// behaviour at the limits, clamped parallel load and limit indication.
// Ports:
//   clk    : single clock, everything on posedge
//   reset  : synchronous, active-high, highest priority
//   bus    : updown_counter_param_if.slave
//            en, updown, wrap_mode, load, load_val (in)
//            count, led, wrap_pulse (registered out), tick (combinational out)
// -----------------------------------------------------------------------------
module updown_counter_param #(
   parameter int WIDTH   = 8,
   parameter int MIN_VAL = 0,
   parameter int MAX_VAL = 255,
   parameter int DIV     = 1_000_000,
   parameter int DIV_W   = 25
) (
   input  logic                   clk,
   input  logic                   reset,
   updown_counter_param_if.slave  bus
);

   // Range limits held one bit wider than the count so +1 / -1 never overflow.
   localparam logic [WIDTH:0]   MIN_X      = (WIDTH+1)'(MIN_VAL);
   localparam logic [WIDTH:0]   MAX_X      = (WIDTH+1)'(MAX_VAL);
   localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic             led_q, led_d;
   logic             wrap_q, wrap_d;
   logic             tick_s;
   logic [WIDTH:0]   count_x_s;
   logic [WIDTH:0]   load_x_s;
   logic [WIDTH:0]   load_lo_s;
   logic [WIDTH:0]   load_clamped_s;

   assign tick_s    = bus.en && (presc_q == PRESC_LAST);
   assign count_x_s = {1'b0, count_q};
   assign load_x_s  = {1'b0, bus.load_val};

   // Clamp the load value into range: raise to MIN first, then cap at MAX.
   always_comb begin
      load_lo_s      = (load_x_s > MIN_X) ? load_x_s : MIN_X;
      load_clamped_s = (load_lo_s < MAX_X) ? load_lo_s : MAX_X;
   end

   // Next-state logic: load beats a step; without a tick only the prescaler moves.
   always_comb begin
      count_d = count_q;
      presc_d = presc_q;
      led_d   = led_q;
      wrap_d  = 1'b0;
      if (bus.load) begin
         count_d = load_clamped_s[WIDTH-1:0];
         presc_d = {DIV_W{1'b0}};
         led_d   = 1'b0;
      end else begin
         if (bus.en) begin
            presc_d = tick_s ? {DIV_W{1'b0}} : (presc_q + DIV_W'(1));
         end else begin
            presc_d = presc_q;
         end
         if (tick_s) begin
            if (bus.updown) begin
               if (count_x_s < MAX_X) begin
                  count_d = count_q + WIDTH'(1);
                  led_d   = 1'b0;
               end else if (bus.wrap_mode) begin
                  count_d = MIN_X[WIDTH-1:0];
                  wrap_d  = 1'b1;
                  led_d   = 1'b0;
               end else begin
                  led_d   = 1'b1;
               end
            end else begin
               if (count_x_s > MIN_X) begin
                  count_d = count_q - WIDTH'(1);
                  led_d   = 1'b0;
               end else if (bus.wrap_mode) begin
                  count_d = MAX_X[WIDTH-1:0];
                  wrap_d  = 1'b1;
                  led_d   = 1'b0;
               end else begin
                  led_d   = 1'b1;
               end
            end
         end else begin
            led_d = led_q;
         end
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= MIN_X[WIDTH-1:0];
         presc_q <= {DIV_W{1'b0}};
         led_q   <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         presc_q <= presc_d;
         led_q   <= led_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.count      = count_q;
   assign bus.led        = led_q;
   assign bus.wrap_pulse = wrap_q;
   assign bus.tick       = tick_s;

endmodule

// File: tb/tb_updown_counter_param.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_param
// Three counter instances driven by a shared stimulus stream:
//   dut0 : WIDTH=3 MIN=0 MAX=7 DIV=1
//   dut1 : WIDTH=3 MIN=0 MAX=7 DIV=4
//   dut2 : WIDTH=4 MIN=2 MAX=9 DIV=1
// Each is compared every cycle against an integer reference model, plus
// explicit expected constants at the interesting points.
// -----------------------------------------------------------------------------
module tb_updown_counter_param;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   updown_counter_param_if #(.WIDTH(3)) ifa ();
   updown_counter_param_if #(.WIDTH(3)) ifb ();
   updown_counter_param_if #(.WIDTH(4)) ifc ();

   updown_counter_param #(.WIDTH(3), .MIN_VAL(0), .MAX_VAL(7), .DIV(1), .DIV_W(1))
      dut0 (.clk(clk), .reset(rst), .bus(ifa));
   updown_counter_param #(.WIDTH(3), .MIN_VAL(0), .MAX_VAL(7), .DIV(4), .DIV_W(2))
      dut1 (.clk(clk), .reset(rst), .bus(ifb));
   updown_counter_param #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(9), .DIV(1), .DIV_W(1))
      dut2 (.clk(clk), .reset(rst), .bus(ifc));

   localparam int WD [3] = '{3, 3, 4};
   localparam int MN [3] = '{0, 0, 2};
   localparam int MX [3] = '{7, 7, 9};
   localparam int DV [3] = '{1, 4, 1};

   typedef struct {
      int cnt;
      int presc;
      int led;
      int wp;
   } st_t;

   st_t         ms [3];
   logic [31:0] oc [3];
   logic [31:0] ol [3];
   logic [31:0] ow [3];
   logic [31:0] ot [3];
   int          total = 0;
   int          bad   = 0;

   // Reference behaviour: one clock edge of the counter described in plain integers.
   function automatic st_t nxt(st_t s, int k, bit r, bit e, bit u, bit w, bit l, int lv);
      st_t n;
      bit  t;
      n    = s;
      n.wp = 0;
      t    = e && (s.presc == DV[k] - 1);
      if (r) begin
         n.cnt = MN[k]; n.presc = 0; n.led = 0;
      end else if (l) begin
         n.cnt   = (lv < MN[k]) ? MN[k] : ((lv > MX[k]) ? MX[k] : lv);
         n.presc = 0;
         n.led   = 0;
      end else begin
         if (e) n.presc = (s.presc + 1) % DV[k];
         if (t) begin
            if (u) begin
               if (s.cnt < MX[k]) begin n.cnt = s.cnt + 1; n.led = 0; end
               else if (w)        begin n.cnt = MN[k]; n.wp = 1; n.led = 0; end
               else                     n.led = 1;
            end else begin
               if (s.cnt > MN[k]) begin n.cnt = s.cnt - 1; n.led = 0; end
               else if (w)        begin n.cnt = MX[k]; n.wp = 1; n.led = 0; end
               else                     n.led = 1;
            end
         end
      end
      return n;
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s dut%0d got=%0h exp=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic gather();
      oc[0] = {29'b0, ifa.count}; oc[1] = {29'b0, ifb.count}; oc[2] = {28'b0, ifc.count};
      ol[0] = {31'b0, ifa.led};   ol[1] = {31'b0, ifb.led};   ol[2] = {31'b0, ifc.led};
      ow[0] = {31'b0, ifa.wrap_pulse}; ow[1] = {31'b0, ifb.wrap_pulse}; ow[2] = {31'b0, ifc.wrap_pulse};
      ot[0] = {31'b0, ifa.tick};  ot[1] = {31'b0, ifb.tick};  ot[2] = {31'b0, ifc.tick};
   endtask

   task automatic drive(input bit r, input bit e, input bit u, input bit w, input bit l, input logic [3:0] v);
      rst = r;
      ifa.en = e; ifa.updown = u; ifa.wrap_mode = w; ifa.load = l; ifa.load_val = v[2:0];
      ifb.en = e; ifb.updown = u; ifb.wrap_mode = w; ifb.load = l; ifb.load_val = v[2:0];
      ifc.en = e; ifc.updown = u; ifc.wrap_mode = w; ifc.load = l; ifc.load_val = v;
   endtask

   // One clock cycle: apply inputs, check tick, clock, check registered outputs.
   task automatic cyc(input bit r, input bit e, input bit u, input bit w, input bit l,
                      input logic [3:0] v, input bit chk_tick);
      drive(r, e, u, w, l, v);
      #2;
      gather();
      if (chk_tick) begin
         for (int k = 0; k < 3; k++)
            chk("tick", k, ot[k], 32'(e && (ms[k].presc == DV[k] - 1)));
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++)
         ms[k] = nxt(ms[k], k, r, e, u, w, l, int'(v) & ((1 << WD[k]) - 1));
      #1;
      gather();
      for (int k = 0; k < 3; k++) begin
         chk("count", k, oc[k], 32'(ms[k].cnt));
         chk("led",   k, ol[k], 32'(ms[k].led));
         chk("wrap",  k, ow[k], 32'(ms[k].wp));
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) ms[k] = '{cnt: 0, presc: 0, led: 0, wp: 0};
      // Reset: state unknown before the first edge, so tick is not checked there.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      chk("rst_count", 2, {28'b0, ifc.count}, 32'd2);
      chk("rst_led",   0, {31'b0, ifa.led},   32'd0);

      // Count up, saturate at 7, led raised after the first blocked step.
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      chk("sat_count", 0, {29'b0, ifa.count}, 32'd7);
      chk("sat_led",   0, {31'b0, ifa.led},   32'd1);

      // Wrap mode: 7 -> 0 with a one-cycle wrap pulse, led cleared.
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
      chk("wrap_count", 0, {29'b0, ifa.count},      32'd0);
      chk("wrap_pulse", 0, {31'b0, ifa.wrap_pulse}, 32'd1);
      chk("wrap_led",   0, {31'b0, ifa.led},        32'd0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
      chk("wrap_once",  0, {31'b0, ifa.wrap_pulse}, 32'd0);

      // Prescaler: freeze with en=0 mid-period, then resume.
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      chk("frz_count", 1, {29'b0, ifb.count}, 32'd0);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      chk("resume_count", 1, {29'b0, ifb.count}, 32'd1);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);

      // Load clamping and load priority over a tick.
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 1'b1);
      chk("ld_hi", 2, {28'b0, ifc.count}, 32'd9);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1);
      chk("ld_lo", 2, {28'b0, ifc.count}, 32'd2);

      // Down at MIN saturates with led; led sticky across updown flip until a step.
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      chk("dn_count", 2, {28'b0, ifc.count}, 32'd2);
      chk("dn_led",   2, {31'b0, ifc.led},   32'd1);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      chk("sticky_led", 2, {31'b0, ifc.led}, 32'd1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      chk("step_count", 2, {28'b0, ifc.count}, 32'd3);
      chk("step_led",   2, {31'b0, ifc.led},   32'd0);

      // Reset mid-count wins over load and en.
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 1'b1);
      chk("mid_rst_count", 2, {28'b0, ifc.count}, 32'd2);
      chk("mid_rst_count", 0, {29'b0, ifa.count}, 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)), 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
